// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: widths, word layout, error codes, FSM states.
// No logic of its own; the word layout is captured as a packed struct that matches the ROM format.
// Imported by the sequencer top and its timeout counter.
package microcode_sequencer_pkg;

   localparam int ADDR_W = 9;
   localparam int INSN_W = 26;

   // Microcode word field positions
   localparam int OP_LSB   = 0;
   localparam int OP_MSB   = 7;
   localparam int SRC1_LSB = 8;
   localparam int SRC1_MSB = 13;
   localparam int SRC0_LSB = 14;
   localparam int SRC0_MSB = 19;
   localparam int DST_LSB  = 20;
   localparam int DST_MSB  = 25;

   localparam int OP_W  = OP_MSB - OP_LSB + 1;
   localparam int REG_W = DST_MSB - DST_LSB + 1;

   // Sticky error codes reported with the done pulse
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_RANGE   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ROMWAIT  = 3'd1,
      ST_READ     = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_WAITDONE = 3'd4
   } seq_state_t;

   // Decoded instruction; member order mirrors the word from MSB to LSB
   typedef struct packed {
      logic [REG_W-1:0] dst;
      logic [REG_W-1:0] src0;
      logic [REG_W-1:0] src1;
      logic [OP_W-1:0]  op;
   } insn_t;

   function automatic insn_t decode_insn(input logic [INSN_W-1:0] word);
      insn_t d;
      d.op   = word[OP_MSB:OP_LSB];
      d.src1 = word[SRC1_MSB:SRC1_LSB];
      d.src0 = word[SRC0_MSB:SRC0_LSB];
      d.dst  = word[DST_MSB:DST_LSB];
      return d;
   endfunction

endpackage

// File: rtl/microcode_sequencer_timeout.sv
// Watchdog for the exec_done wait: counts stalled cycles, flags when the limit is about to be hit.
// Latency: o_expired is a compare on the registered count, valid in the same cycle.
// No backpressure; clear has priority over enable, count saturates at the flag point.
module seq_timeout_counter
   import microcode_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   // The cycle that would make the count reach TIMEOUT is the abort cycle
   assign w_last    = (r_count == CNT_W'(TIMEOUT - 1));
   assign o_expired = w_last;

   // Stall counter: cleared at each handshake, advanced while waiting
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_last) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/microcode_sequencer.sv
// Walks the microcode ROM over a host-given range and issues each decoded word to the GF(3^m) datapath.
// Latency: 4 cycles per instruction minimum (ROM wait, read/decode, issue, done wait); done 1 cycle after the last exec_done.
// Backpressure: fields hold stable while exec_ready is low; waits for exec_done up to TIMEOUT cycles, then aborts.
module microcode_sequencer
   import microcode_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [ADDR_W-1:0] i_end_addr,
   output logic              o_busy,
   output logic              o_done,
   output logic [1:0]        o_err,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [INSN_W-1:0] i_rom_data,
   output logic              o_exec_valid,
   input  logic              i_exec_ready,
   output logic [OP_W-1:0]   o_exec_op,
   output logic [REG_W-1:0]  o_exec_src1,
   output logic [REG_W-1:0]  o_exec_src0,
   output logic [REG_W-1:0]  o_exec_dst,
   input  logic              i_exec_done
);

   seq_state_t        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_end;
   logic              r_busy;
   logic              r_done;
   logic [1:0]        r_err;
   logic              r_exec_valid;
   insn_t             r_insn;

   logic w_cnt_clear;
   logic w_cnt_enable;
   logic w_expired;

   // Counter restarts on the accepted handshake and runs only while exec_done is pending
   assign w_cnt_clear  = (r_state == ST_ISSUE) && i_exec_ready;
   assign w_cnt_enable = (r_state == ST_WAITDONE) && !i_exec_done;

   seq_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (w_cnt_clear),
      .i_enable  (w_cnt_enable),
      .o_expired (w_expired)
   );

   // Sequencer FSM with registered outputs; done is a single-cycle pulse
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= '0;
         r_end        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= ERR_OK;
         r_exec_valid <= 1'b0;
         r_insn       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (i_end_addr < i_start_addr) begin
                     // Bad range: report immediately, never touch the ROM
                     r_done <= 1'b1;
                     r_err  <= ERR_RANGE;
                  end else begin
                     // End address is captured so a host change mid-run cannot derail the walk
                     r_pc    <= i_start_addr;
                     r_end   <= i_end_addr;
                     r_err   <= ERR_OK;
                     r_busy  <= 1'b1;
                     r_state <= ST_ROMWAIT;
                  end
               end
            end
            ST_ROMWAIT: begin
               r_state <= ST_READ;
            end
            ST_READ: begin
               if (i_rom_data == '0) begin
                  // All-zero word means unprogrammed store
                  r_done  <= 1'b1;
                  r_err   <= ERR_ILLEGAL;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_insn       <= decode_insn(i_rom_data);
                  r_exec_valid <= 1'b1;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (i_exec_ready) begin
                  r_exec_valid <= 1'b0;
                  r_state      <= ST_WAITDONE;
               end
            end
            ST_WAITDONE: begin
               if (i_exec_done) begin
                  if (r_pc == r_end) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_pc    <= r_pc + ADDR_W'(1);
                     r_state <= ST_ROMWAIT;
                  end
               end else if (w_expired) begin
                  r_done  <= 1'b1;
                  r_err   <= ERR_TIMEOUT;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_exec_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_rom_addr   = r_pc;
   assign o_exec_valid = r_exec_valid;
   assign o_exec_op    = r_insn.op;
   assign o_exec_src1  = r_insn.src1;
   assign o_exec_src0  = r_insn.src0;
   assign o_exec_dst   = r_insn.dst;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: ROM and datapath models, directed program runs then randomized runs.
// Expected timing comes from per-instruction cycle arithmetic; expected words come from walking the ROM array.
// Ready/done responder supports stall lengths, never-done, and handshake/start noise.
module tb_microcode_sequencer;
   import microcode_sequencer_pkg::*;

   localparam int TO = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic              busy;
   logic              done;
   logic [1:0]        err;
   logic [ADDR_W-1:0] rom_addr;
   logic [INSN_W-1:0] rom_data;
   logic              exec_valid;
   logic              exec_ready;
   logic [OP_W-1:0]   exec_op;
   logic [REG_W-1:0]  exec_src1;
   logic [REG_W-1:0]  exec_src0;
   logic [REG_W-1:0]  exec_dst;
   logic              exec_done;

   logic [INSN_W-1:0] rom [0:511];
   logic [INSN_W-1:0] issued_q [$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Program store model with a one-cycle registered read
   always @(posedge clk) rom_data <= rom[rom_addr];

   microcode_sequencer #(.TIMEOUT(TO)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_start      (start),
      .i_start_addr (start_addr),
      .i_end_addr   (end_addr),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_rom_addr   (rom_addr),
      .i_rom_data   (rom_data),
      .o_exec_valid (exec_valid),
      .i_exec_ready (exec_ready),
      .o_exec_op    (exec_op),
      .o_exec_src1  (exec_src1),
      .o_exec_src0  (exec_src0),
      .o_exec_dst   (exec_dst),
      .i_exec_done  (exec_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one program from a start pulse until done, checking against the range/timing model
   task automatic run_prog(input string tag, input int sa, input int ea,
                           input int rd0, input int rd, input int dd,
                           input bit never, input bit noise, output int done_cyc);
      logic [INSN_W-1:0] exp_q [$];
      int ill_k, exp_cyc, cyc, rcnt, dcnt, n_cmp_issue;
      logic [1:0] exp_err, got_err;
      logic got_busy;
      bit seen, overlap, unstable, prev_v, hs_prev, hs, waiting;
      logic [INSN_W-1:0] cur;
      logic [ADDR_W-1:0] addr_before;

      issued_q.delete();
      ill_k = -1; seen = 0; overlap = 0; unstable = 0; prev_v = 0; hs_prev = 0;
      waiting = 0; rcnt = 0; dcnt = 0; done_cyc = -1; got_err = 2'bxx; got_busy = 1'bx;
      cur = '0;

      // Reference model: which words get issued, final error, and done cycle
      if (ea < sa) begin
         exp_err = ERR_RANGE;
         exp_cyc = 1;
      end else begin
         for (int a = sa; a <= ea; a++) begin
            if (rom[a] == '0) begin
               ill_k = exp_q.size();
               break;
            end
            exp_q.push_back(rom[a]);
         end
         if (never && exp_q.size() > 0) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
            exp_err = ERR_TIMEOUT;
            exp_cyc = 3 + rd0 + TO + 1;
         end else begin
            exp_cyc = 1;
            for (int i = 0; i < exp_q.size(); i++) exp_cyc += 4 + ((i == 0) ? rd0 : rd) + dd;
            if (ill_k >= 0) begin
               exp_cyc += 2;
               exp_err = ERR_ILLEGAL;
            end else begin
               exp_err = ERR_OK;
            end
         end
      end

      addr_before = rom_addr;
      start_addr  = ADDR_W'(sa);
      end_addr    = ADDR_W'(ea);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!seen && cyc <= exp_cyc + 40) begin
         if (cyc == 1 && ea >= sa) begin
            chk({tag, " busy after start"}, 32'(busy), 32'd1);
            chk({tag, " err cleared at start"}, 32'(err), 32'(ERR_OK));
         end
         if (busy && done) overlap = 1;
         if (done) begin
            seen = 1; done_cyc = cyc; got_err = err; got_busy = busy;
         end
         // Datapath responder
         hs = 0;
         exec_ready = 1'b0;
         exec_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (hs_prev) begin
            waiting = 1; dcnt = dd;
         end
         if (waiting) begin
            exec_done = 1'b0;
            if (!never) begin
               if (dcnt == 0) begin
                  exec_done = 1'b1; waiting = 0;
               end else begin
                  dcnt--;
               end
            end
         end
         if (exec_valid) begin
            if (!prev_v) begin
               cur = {exec_dst, exec_src0, exec_src1, exec_op};
               issued_q.push_back(cur);
               rcnt = (issued_q.size() == 1) ? rd0 : rd;
            end else if ({exec_dst, exec_src0, exec_src1, exec_op} !== cur) begin
               unstable = 1;
            end
            if (rcnt == 0) begin
               exec_ready = 1'b1; hs = 1;
            end else begin
               rcnt--;
            end
         end else if (noise) begin
            exec_ready = 1'($urandom_range(0, 1));
         end
         prev_v  = exec_valid;
         hs_prev = hs;
         // Start requests while busy must be ignored
         start = 1'b0;
         if (noise && busy && !done) begin
            start      = 1'($urandom_range(0, 1));
            start_addr = ADDR_W'($urandom_range(0, 511));
         end
         if (!seen) begin
            @(negedge clk);
            cyc++;
         end
      end

      chk({tag, " done seen"}, 32'(seen), 32'd1);
      chk({tag, " done cycle"}, 32'(done_cyc), 32'(exp_cyc));
      chk({tag, " err"}, 32'(got_err), 32'(exp_err));
      chk({tag, " busy low at done"}, 32'(got_busy), 32'd0);
      chk({tag, " busy/done overlap"}, 32'(overlap), 32'd0);
      chk({tag, " fields stable under stall"}, 32'(unstable), 32'd0);
      chk({tag, " issue count"}, 32'(issued_q.size()), 32'(exp_q.size()));
      n_cmp_issue = (issued_q.size() < exp_q.size()) ? issued_q.size() : exp_q.size();
      for (int i = 0; i < n_cmp_issue; i++)
         chk({tag, " issued word"}, 32'(issued_q[i]), 32'(exp_q[i]));
      if (ea < sa) chk({tag, " no rom fetch"}, 32'(rom_addr), 32'(addr_before));
      @(negedge clk);
      exec_ready = 1'b0;
      exec_done  = 1'b0;
      start      = 1'b0;
      chk({tag, " done is one pulse"}, 32'(done), 32'd0);
      chk({tag, " err sticky"}, 32'(err), 32'(exp_err));
   endtask

   initial begin
      int dc;
      logic [INSN_W-1:0] w;

      reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
      exec_ready = 1'b0; exec_done = 1'b0;
      for (int a = 0; a < 512; a++) rom[a] = '0;
      rom[0]  = 26'h030c042;
      rom[1]  = 26'h0514045;
      rom[3]  = 26'h2a5c3b7;
      rom[4]  = 26'h1234567;
      rom[10] = 26'h0abcdef;
      rom[12] = 26'h0fedcba;
      for (int a = 20; a < 512; a++) begin
         w = INSN_W'($urandom);
         if (w == '0 || $urandom_range(0, 11) != 0) w = w | 26'h1;
         else w = '0;
         rom[a] = w;
      end
      rom[511] = 26'h3ffffff;

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset valid", 32'(exec_valid), 32'd0);
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset fields", 32'({exec_dst, exec_src0, exec_src1, exec_op}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Two-instruction program, ready/done immediate
      run_prog("basic", 0, 1, 0, 0, 0, 1'b0, 1'b0, dc);
      chk("basic done at cycle 9", 32'(dc), 32'd9);
      w = (issued_q.size() > 0) ? issued_q[0] : '1;
      chk("basic i0 op", 32'(w[7:0]), 32'h42);
      chk("basic i0 src1", 32'(w[13:8]), 32'd0);
      chk("basic i0 src0", 32'(w[19:14]), 32'd3);
      chk("basic i0 dst", 32'(w[25:20]), 32'd3);
      w = (issued_q.size() > 1) ? issued_q[1] : '1;
      chk("basic i1 op", 32'(w[7:0]), 32'h45);
      chk("basic i1 src1", 32'(w[13:8]), 32'd0);
      chk("basic i1 src0", 32'(w[19:14]), 32'd5);
      chk("basic i1 dst", 32'(w[25:20]), 32'd5);

      // Ready held low 5 cycles on the first instruction
      run_prog("stall", 0, 1, 5, 0, 0, 1'b0, 1'b1, dc);
      chk("stall done delayed by 5", 32'(dc), 32'd14);

      // Unprogrammed word inside the range
      run_prog("illegal", 10, 12, 0, 0, 0, 1'b0, 1'b0, dc);
      chk("illegal done cycle", 32'(dc), 32'd7);

      // exec_done never arrives
      run_prog("timeout", 0, 1, 0, 0, 0, 1'b1, 1'b0, dc);
      chk("timeout 16 after handshake", 32'(dc), 32'd19);
      run_prog("after timeout", 0, 1, 1, 2, 1, 1'b0, 1'b1, dc);

      // Reversed range
      run_prog("bad range", 5, 4, 0, 0, 0, 1'b0, 1'b0, dc);

      // Top of the address space
      run_prog("addr 511", 511, 511, 0, 0, 2, 1'b0, 1'b1, dc);

      // Reset in WAITDONE
      start_addr = 9'd3; end_addr = 9'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst: valid before reset", 32'(exec_valid), 32'd1);
      exec_ready = 1'b1;
      @(negedge clk);
      exec_ready = 1'b0;
      chk("rst: busy in waitdone", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst: busy", 32'(busy), 32'd0);
      chk("rst: done", 32'(done), 32'd0);
      chk("rst: err", 32'(err), 32'd0);
      chk("rst: valid", 32'(exec_valid), 32'd0);
      chk("rst: rom_addr", 32'(rom_addr), 32'd0);
      chk("rst: fields", 32'({exec_dst, exec_src0, exec_src1, exec_op}), 32'd0);
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      chk("rst: no done pulse", 32'(done), 32'd0);
      chk("rst: stays idle", 32'(busy), 32'd0);
      run_prog("post reset", 3, 4, 0, 1, 0, 1'b0, 1'b1, dc);

      // Randomized programs
      for (int t = 0; t < 30; t++) begin
         int sa, ea;
         sa = $urandom_range(20, 511);
         ea = sa + $urandom_range(0, 5);
         if (ea > 511) ea = 511;
         if ($urandom_range(0, 7) == 0) ea = sa - 1 - $urandom_range(0, 10);
         run_prog("random", sa, ea, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'b1, dc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Sequences the pairing core's microcode program store (512 x 26-bit words, registered read, 1-cycle latency).
- Host supplies a start/end address range; block walks the ROM, decodes each word, and issues it to the GF(3^m) arithmetic datapath with a valid/ready + done handshake.
- Sits between the top-level command interface and the arithmetic unit/register file; sole master of the ROM address bus.

Parameters:
- ADDR_W, 9, ROM address width
- INSN_W, 26, microcode word width
- TIMEOUT, 1023, max cycles waiting for exec_done before abort (counter width = clog2(TIMEOUT+1))

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- start_addr  in  ADDR_W  first instruction address
- end_addr  in  ADDR_W  last instruction address (inclusive)
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at program end or abort
- err  out  2  00 ok, 01 illegal word, 10 timeout, 11 bad range; sticky until next accepted start
- rom_addr  out  ADDR_W  registered ROM address (= pc)
- rom_data  in  INSN_W  ROM output, valid one cycle after rom_addr
- exec_valid  out  1  instruction presented to datapath
- exec_ready  in  1  datapath accepts instruction
- exec_op  out  8  word[7:0]
- exec_src1  out  6  word[13:8]
- exec_src0  out  6  word[19:14]
- exec_dst  out  6  word[25:20]
- exec_done  in  1  datapath finished current instruction

Behaviour:
- Reset (sync): state IDLE, pc=0, busy=0, done=0, err=00, exec_valid=0, exec_* fields=0, timeout counter=0; all outputs registered. Reset mid-program drops exec_valid on that same edge; no done pulse.
- States: IDLE, ROMWAIT, READ, ISSUE, WAITDONE.
- IDLE: start=1 -> if end_addr < start_addr: done=1, err=11 next cycle, stay IDLE. Else pc<=start_addr, err<=00, busy<=1, -> ROMWAIT. start in any other state is ignored.
- ROMWAIT: one cycle for ROM registered read -> READ.
- READ: if rom_data == 0 (unprogrammed word): done=1, err=01, busy=0 -> IDLE. Else latch fields into exec_* -> ISSUE.
- ISSUE: exec_valid=1, fields held stable until exec_ready=1; handshake completes in the cycle both are high -> WAITDONE, exec_valid=0, counter cleared.
- WAITDONE: exec_done=1 -> if pc == end_addr: done=1, busy=0 -> IDLE; else pc<=pc+1 -> ROMWAIT. Otherwise counter++; counter reaching TIMEOUT: done=1, err=10, busy=0 -> IDLE.
- exec_done outside WAITDONE is ignored. exec_done asserted in the first WAITDONE cycle is legal.
- Minimum per-instruction cost, with ready and done immediate: 4 cycles. Single-instruction program: start at cycle 0 -> exec_valid in cycle 3 -> exec_done in cycle 4 -> done in cycle 5.
- pc never wraps: end_addr >= start_addr is guaranteed by the range check. start_addr = end_addr = 511 is legal.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package: INSN_W, ADDR_W, field bit positions (OP 7:0, SRC1 13:8, SRC0 19:14, DST 25:20), err codes, state encoding.
- Sub-module: seq_timeout_counter (clear/enable/expired).
- FSM and field latch stay in the top.

Test Plan:
- ROM preloaded 0x30c042 @0, 0x514045 @1; start 0..1, ready/done tied high -> exec_dst=3, src0=3, src1=0, op=0x42, then exec_dst=5, src0=5, src1=0, op=0x45; done pulse at cycle 9; err=00.
- Same program, exec_ready held low 5 cycles -> exec_valid and fields stable throughout; done delayed exactly 5 cycles.
- Range start=10, end=12 with word @11 = 0 -> one instruction issued; done with err=01 the cycle after READ of addr 11; busy low.
- exec_done never asserted, TIMEOUT=15 -> done and err=10 exactly 16 cycles after the handshake; next start clears err.
- start_addr=5, end_addr=4 -> done and err=11 next cycle, no ROM fetch, no exec_valid.
- reset asserted during WAITDONE -> next cycle all outputs at reset values; later start runs normally; start pulsed while busy has no effect.
